restoring_div_ctrl: RTL and testbench

RESTORING_DIV_CTRL -- requirements
Module: restoring_div_ctrl

---
 rtl/div_pkg.sv | 19 +
 rtl/div_addsub.sv | 18 +
 rtl/restoring_div_ctrl.sv | 136 +++++++++++++
 tb/tb_restoring_div_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared parameters and state encoding for the restoring divider control and its Q stage.
package div_pkg;

  parameter int unsigned WIDTH      = 4;
  parameter int unsigned ITERATIONS = 4;
  parameter int unsigned CNT_W      = $clog2(ITERATIONS);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StSub,
    StQset,
    StDone
  } div_state_e;

endpackage

// File: rtl/div_addsub.sv
// Partial-remainder adder/subtractor: res = a -/+ {0, m}, wrapping modulo 2^(WIDTH+1).
module div_addsub
  import div_pkg::*;
(
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] m,
  input  logic             sub,
  output logic [WIDTH:0]   res
);

  logic [WIDTH:0] m_ext;

  always_comb begin
    m_ext = {1'b0, m};
    res   = sub ? (a - m_ext) : (a + m_ext);
  end

endmodule

// File: rtl/restoring_div_ctrl.sv
// Control FSM and A/M datapath of a restoring divider driving an external Q shift register.
module restoring_div_ctrl
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] q_cur,
  output logic             q_load,
  output logic [WIDTH-1:0] q_load_data,
  output logic             shift_left_enable_q,
  output logic             a_sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remainder,
  output logic             dz_err
);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] qld_q, qld_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;

  logic             addsub_sub;
  logic [WIDTH:0]   addsub_res;

  // SUB subtracts; QSET reuses the same unit to add M back when A went negative.
  div_addsub u_addsub (
    .a   (a_q),
    .m   (m_q),
    .sub (addsub_sub),
    .res (addsub_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      m_q     <= '0;
      qld_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      qld_q   <= qld_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    a_d                 = a_q;
    m_d                 = m_q;
    qld_d               = qld_q;
    rem_d               = rem_q;
    cnt_d               = cnt_q;
    dz_d                = dz_q;
    addsub_sub          = (state_q == StSub);
    q_load              = 1'b0;
    shift_left_enable_q = 1'b0;
    a_sign              = 1'b0;
    busy                = 1'b0;
    done                = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor != '0) begin
            m_d     = divisor;
            qld_d   = dividend;
            a_d     = '0;
            dz_d    = 1'b0;
            rem_d   = '0;
            state_d = StLoad;
          end else begin
            // Divide by zero skips the datapath entirely; Q is left untouched.
            dz_d    = 1'b1;
            rem_d   = dividend;
            state_d = StDone;
          end
        end
      end
      StLoad: begin
        busy    = 1'b1;
        q_load  = 1'b1;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        busy    = 1'b1;
        a_d     = {a_q[WIDTH-1:0], q_cur[WIDTH-1]};
        state_d = StSub;
      end
      StSub: begin
        busy    = 1'b1;
        a_d     = addsub_res;
        state_d = StQset;
      end
      StQset: begin
        busy                = 1'b1;
        shift_left_enable_q = 1'b1;
        a_sign              = a_q[WIDTH];
        if (a_q[WIDTH]) begin
          a_d = addsub_res;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          rem_d   = a_d[WIDTH-1:0];
          state_d = StDone;
        end else begin
          state_d = StShift;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign q_load_data = qld_q;
  assign remainder   = rem_q;
  assign dz_err      = dz_q;

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Self-checking bench: directed vector table, hand-written corner sequences and random divides
// compared against plain integer division, with a behavioural Q shift register model.
module tb_restoring_div_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] q_cur;
  logic       q_load;
  logic [3:0] q_load_data;
  logic       shift_left_enable_q;
  logic       a_sign;
  logic       busy;
  logic       done;
  logic [3:0] remainder;
  logic       dz_err;

  int n_tests = 0;
  int n_fail  = 0;

  restoring_div_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .dividend            (dividend),
    .divisor             (divisor),
    .q_cur               (q_cur),
    .q_load              (q_load),
    .q_load_data         (q_load_data),
    .shift_left_enable_q (shift_left_enable_q),
    .a_sign              (a_sign),
    .busy                (busy),
    .done                (done),
    .remainder           (remainder),
    .dz_err              (dz_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External Q stage: load on q_load, shift left inserting ~a_sign.
  logic [3:0] qm;
  always @(posedge clk) begin
    if (rst) qm <= 4'd0;
    else if (q_load) qm <= q_load_data;
    else if (shift_left_enable_q) qm <= {qm[2:0], ~a_sign};
  end
  assign q_cur = qm;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int lat;
    int nload;
    int nshift;
    int nsign1;
    int inv_err;
    int busy_err;
    int q;
    int r;
    int dz;
  } obs_t;

  // Issue one divide and observe until done or the cycle budget expires.
  task automatic run_div(input logic [3:0] dd, input logic [3:0] dv, output obs_t o);
    o = '{default: 0};
    @(negedge clk);
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = 4'($urandom); divisor = 4'($urandom);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (q_load) o.nload++;
      if (shift_left_enable_q) begin
        o.nshift++;
        if (a_sign) o.nsign1++;
      end
      if (int'(q_load) + int'(shift_left_enable_q) + int'(done) > 1) o.inv_err++;
      if (a_sign && !shift_left_enable_q) o.inv_err++;
      if (done) begin
        o.lat = c; o.q = int'(q_cur); o.r = int'(remainder); o.dz = int'(dz_err);
        if (busy) o.busy_err++;
        break;
      end
      if (!busy) o.busy_err++;
    end
  endtask

  // Reference: plain integer division; divisor 0 reports the dividend as remainder.
  task automatic div_and_check(input string tag, input logic [3:0] dd, input logic [3:0] dv);
    obs_t o;
    int eq, er, edz, elat, eload, eshift, esign;
    if (dv == 4'd0) begin
      eq = 0; er = int'(dd); edz = 1; elat = 1; eload = 0; eshift = 0; esign = 0;
    end else begin
      eq = int'(dd) / int'(dv); er = int'(dd) % int'(dv); edz = 0; elat = 14;
      eload = 1; eshift = 4; esign = 4 - $countones(eq[3:0]);
    end
    run_div(dd, dv, o);
    check({tag, " latency"}, o.lat, elat);
    check({tag, " remainder"}, o.r, er);
    check({tag, " dz_err"}, o.dz, edz);
    if (edz == 0) check({tag, " quotient"}, o.q, eq);
    check({tag, " q_load count"}, o.nload, eload);
    check({tag, " shift count"}, o.nshift, eshift);
    check({tag, " a_sign ones"}, o.nsign1, esign);
    check({tag, " pulse invariants"}, o.inv_err, 0);
    check({tag, " busy profile"}, o.busy_err, 0);
    @(negedge clk);
    check({tag, " remainder held"}, int'(remainder), er);
    check({tag, " idle after done"}, int'({busy, done}), 0);
  endtask

  typedef struct {
    logic [3:0] dd;
    logic [3:0] dv;
    int         eq;
    int         er;
    int         edz;
    int         esign;
  } vec_t;

  vec_t vecs[8];

  initial begin
    obs_t o;
    int   ndone;

    vecs[0] = '{dd: 4'd13, dv: 4'd3,  eq: 4,  er: 1, edz: 0, esign: 3};
    vecs[1] = '{dd: 4'd15, dv: 4'd1,  eq: 15, er: 0, edz: 0, esign: 0};
    vecs[2] = '{dd: 4'd7,  dv: 4'd9,  eq: 0,  er: 7, edz: 0, esign: 4};
    vecs[3] = '{dd: 4'd5,  dv: 4'd0,  eq: 0,  er: 5, edz: 1, esign: 0};
    vecs[4] = '{dd: 4'd9,  dv: 4'd2,  eq: 4,  er: 1, edz: 0, esign: 3};
    vecs[5] = '{dd: 4'd0,  dv: 4'd5,  eq: 0,  er: 0, edz: 0, esign: 4};
    vecs[6] = '{dd: 4'd15, dv: 4'd15, eq: 1,  er: 0, edz: 0, esign: 3};
    vecs[7] = '{dd: 4'd8,  dv: 4'd0,  eq: 0,  er: 8, edz: 1, esign: 0};

    rst = 1'b1; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset outputs",
          int'({q_load, shift_left_enable_q, a_sign, busy, done, dz_err, remainder, q_load_data}),
          0);

    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i].dd, vecs[i].dv, o);
      check($sformatf("vec%0d latency", i), o.lat, vecs[i].edz ? 1 : 14);
      check($sformatf("vec%0d remainder", i), o.r, vecs[i].er);
      check($sformatf("vec%0d dz_err", i), o.dz, vecs[i].edz);
      if (vecs[i].edz == 0) check($sformatf("vec%0d quotient", i), o.q, vecs[i].eq);
      check($sformatf("vec%0d shifts", i), o.nshift, vecs[i].edz ? 0 : 4);
      check($sformatf("vec%0d q_loads", i), o.nload, vecs[i].edz ? 0 : 1);
      check($sformatf("vec%0d a_sign ones", i), o.nsign1, vecs[i].esign);
      check($sformatf("vec%0d invariants", i), o.inv_err + o.busy_err, 0);
    end

    // start while busy and in the DONE cycle must both be ignored.
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk);
    #1 start = 1'b0;
    o = '{default: 0};
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        o.lat = c; o.q = int'(q_cur); o.r = int'(remainder); o.dz = int'(dz_err);
      end
      start = (c == 5) || done; dividend = 4'd15; divisor = 4'd0;
      if (done) break;
    end
    @(posedge clk);
    #1 start = 1'b0;
    check("ignore-start latency", o.lat, 14);
    check("ignore-start quotient", o.q, 4);
    check("ignore-start remainder", o.r, 1);
    check("ignore-start dz_err", o.dz, 0);
    @(negedge clk);
    check("start in DONE ignored", int'({busy, done, dz_err}), 0);
    @(negedge clk);
    check("no second done", int'(done), 0);
    check("remainder unchanged", int'(remainder), 1);

    // rst in SUB of iteration 2 aborts; outputs clear and no done follows.
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    check("busy before abort", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort outputs",
          int'({q_load, shift_left_enable_q, a_sign, busy, done, dz_err, remainder, q_load_data}),
          0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("no activity after abort", ndone, 0);
    div_and_check("post-reset 9/2", 4'd9, 4'd2);

    // rst wins over start in IDLE.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 4'd6; divisor = 4'd0;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst beats start", int'({busy, done, dz_err}), 0);

    for (int i = 0; i < 30; i++) begin
      div_and_check($sformatf("rand%0d", i), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
